// File: rtl/sap1_pkg.sv
// Constants shared across the SAP-1 control path: sequencer state codes,
// default step geometry (also used by the control ROM) and step-index sizing.
package sap1_pkg;

   localparam int SAP1_MAX_STEPS   = 8;
   localparam int SAP1_FETCH_STEPS = 2;

   localparam logic [1:0] SEQ_FETCH = 2'd0;
   localparam logic [1:0] SEQ_EXEC  = 2'd1;
   localparam logic [1:0] SEQ_HALT  = 2'd2;

   // Width of a step index; never narrower than one bit.
   function automatic int sap1_step_width(input int maxSteps);
      int w;
      w = $clog2(maxSteps);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/step_request_latch.sv
// Holds one outstanding single-step request until a tick consumes it.
// Shared with the debug front panel.
module step_request_latch (
   input  logic clk,
   input  logic rst_n,
   input  logic i_single_step,
   input  logic i_step_req,
   input  logic i_tick,
   output logic o_pending
);

   logic r_pending;

   // Requests collapse into one flag; leaving single-step mode discards it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= 1'b0;
      end else if (!i_single_step || i_tick) begin
         r_pending <= 1'b0;
      end else if (i_step_req) begin
         r_pending <= 1'b1;
      end
   end

   assign o_pending = r_pending;

endmodule

// File: rtl/microstep_sequencer.sv
// Phase-aware microstep sequencer: fixed fetch phase, per-opcode execute length,
// early termination, halt, single-step and a retired-instruction counter.
module microstep_sequencer
   import sap1_pkg::*;
#(
   parameter  int MAX_STEPS   = SAP1_MAX_STEPS,
   parameter  int FETCH_STEPS = SAP1_FETCH_STEPS,
   parameter  int COUNT_WIDTH = 16,
   parameter  int HALT_STICKY = 0,
   localparam int STEP_WIDTH  = sap1_step_width(MAX_STEPS)
) (
   input  logic                   mclk,
   input  logic                   mrst_n,
   input  logic                   mclk_en,
   input  logic                   i_halt,
   input  logic                   i_adv,
   input  logic [STEP_WIDTH-1:0]  i_exec_len,
   input  logic                   i_single_step,
   input  logic                   i_step_req,
   output logic [STEP_WIDTH-1:0]  o_step,
   output logic                   o_fetch,
   output logic                   o_instr_done,
   output logic                   o_halted,
   output logic [COUNT_WIDTH-1:0] o_retired
);

   localparam logic [STEP_WIDTH-1:0] FETCH_LAST = STEP_WIDTH'(FETCH_STEPS - 1);
   localparam logic [STEP_WIDTH-1:0] EXEC_FIRST = STEP_WIDTH'(FETCH_STEPS);
   localparam logic [STEP_WIDTH-1:0] EXEC_MAX   = STEP_WIDTH'(MAX_STEPS - FETCH_STEPS);
   localparam logic [STEP_WIDTH:0]   FETCH_WIDE = (STEP_WIDTH + 1)'(FETCH_STEPS);
   localparam logic [STEP_WIDTH:0]   ONE_WIDE   = (STEP_WIDTH + 1)'(1);

   logic [STEP_WIDTH-1:0]  r_step;
   logic [1:0]             r_state;
   logic [STEP_WIDTH-1:0]  r_len;
   logic                   r_done;
   logic                   r_halted;
   logic                   r_haltLatched;
   logic [COUNT_WIDTH-1:0] r_retired;

   logic                   w_haltActive;
   logic                   w_pending;
   logic                   w_tick;
   logic                   w_lastExec;
   logic [STEP_WIDTH-1:0]  w_lenClamped;
   logic [STEP_WIDTH-1:0]  w_stepNext;
   logic [1:0]             w_stateNext;
   logic [STEP_WIDTH-1:0]  w_lenNext;
   logic                   w_retire;

   assign w_haltActive = i_halt | ((HALT_STICKY != 0) ? r_haltLatched : 1'b0);
   assign w_tick       = mclk_en & ~w_haltActive & (~i_single_step | i_step_req | w_pending);
   assign w_lenClamped = (i_exec_len > EXEC_MAX) ? EXEC_MAX : i_exec_len;

   // Compared one bit wider so FETCH_STEPS+len may equal MAX_STEPS.
   assign w_lastExec = (({1'b0, r_step} + ONE_WIDE) == (FETCH_WIDE + {1'b0, r_len}));

   step_request_latch u_stepReq (
      .clk           (mclk),
      .rst_n         (mrst_n),
      .i_single_step (i_single_step),
      .i_step_req    (i_step_req),
      .i_tick        (w_tick),
      .o_pending     (w_pending)
   );

   always_comb begin
      w_stepNext  = r_step;
      w_stateNext = r_state;
      w_lenNext   = r_len;
      w_retire    = 1'b0;
      if (w_tick) begin
         case (r_state)
            SEQ_EXEC: begin
               if (w_lastExec || i_adv) begin
                  w_retire    = 1'b1;
                  w_stepNext  = '0;
                  w_stateNext = SEQ_FETCH;
               end else begin
                  w_stepNext = r_step + STEP_WIDTH'(1);
               end
            end
            default: begin
               if (r_step != FETCH_LAST) begin
                  w_stepNext = r_step + STEP_WIDTH'(1);
               end else begin
                  w_lenNext = w_lenClamped;
                  if (w_lenClamped == '0) begin
                     w_retire    = 1'b1;
                     w_stepNext  = '0;
                     w_stateNext = SEQ_FETCH;
                  end else begin
                     w_stepNext  = EXEC_FIRST;
                     w_stateNext = SEQ_EXEC;
                  end
               end
            end
         endcase
      end
   end

   // The done pulse follows every clock so it lasts one mclk even when disabled.
   always_ff @(posedge mclk or negedge mrst_n) begin
      if (!mrst_n) begin
         r_step        <= '0;
         r_state       <= SEQ_FETCH;
         r_len         <= '0;
         r_done        <= 1'b0;
         r_halted      <= 1'b0;
         r_haltLatched <= 1'b0;
         r_retired     <= '0;
      end else begin
         r_step  <= w_stepNext;
         r_state <= w_stateNext;
         r_len   <= w_lenNext;
         r_done  <= w_retire;
         if (w_retire) begin
            r_retired <= r_retired + COUNT_WIDTH'(1);
         end
         if (mclk_en) begin
            r_halted <= w_haltActive;
            if (i_halt) begin
               r_haltLatched <= 1'b1;
            end
         end
      end
   end

   assign o_step       = r_step;
   assign o_fetch      = (r_state == SEQ_FETCH);
   assign o_instr_done = r_done;
   assign o_halted     = r_halted;
   assign o_retired    = r_retired;

endmodule
